// File: rtl/kb_pkg.sv
// Shared types and constants for the maze keyboard command path.
package kb_pkg;

  typedef logic [2:0] cmd_t;

  localparam cmd_t CMD_UP      = 3'd0;
  localparam cmd_t CMD_LEFT    = 3'd1;
  localparam cmd_t CMD_DOWN    = 3'd2;
  localparam cmd_t CMD_RIGHT   = 3'd3;
  localparam cmd_t CMD_RESTART = 3'd4;

  localparam logic [7:0] KEY_W = 8'h1D;
  localparam logic [7:0] KEY_A = 8'h1C;
  localparam logic [7:0] KEY_S = 8'h1B;
  localparam logic [7:0] KEY_D = 8'h23;
  localparam logic [7:0] KEY_R = 8'h2D;
  localparam logic [7:0] KEY_P = 8'h4D;

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_DECODE
  } state_t;

  typedef struct packed {
    logic hit;
    cmd_t cmd;
  } key_dec_t;

  function automatic key_dec_t key_decode(
    input logic [7:0] code
  );
    key_dec_t d;
    d.hit = 1'b1;
    d.cmd = CMD_UP;
    unique case (1'b1)
      code == KEY_W: d.cmd = CMD_UP;
      code == KEY_A: d.cmd = CMD_LEFT;
      code == KEY_S: d.cmd = CMD_DOWN;
      code == KEY_D: d.cmd = CMD_RIGHT;
      code == KEY_R: d.cmd = CMD_RESTART;
      default:       d.hit = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/kb_move_ctrl_fifo.sv
// Small valid/ready command queue with a registered head output.
// The head register keeps its last value while the queue is empty.
module kb_cmd_fifo
  import kb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  cmd_t in_data,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  output cmd_t out_data
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  cmd_t        mem [DEPTH];
  cmd_t        head_q;
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic [PW:0] rd_inc;
  logic [PW:0] count;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  assign count  = wr_ptr - rd_ptr;
  assign rd_inc = rd_ptr + PTR_ONE;
  assign empty  = wr_ptr == rd_ptr;
  assign full   = (wr_ptr[PW] != rd_ptr[PW])
               && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot a full queue needs.
  assign in_ready  = !full || pop;
  assign push      = in_valid && in_ready;
  assign out_data  = head_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head_q <= CMD_UP;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_inc;
      end
      if (push && (empty || (pop && count == PTR_ONE))) begin
        head_q <= in_data;
      end else if (pop && count != PTR_ONE) begin
        head_q <= mem[rd_inc[PW-1:0]];
      end
    end
  end

endmodule

// File: rtl/kb_move_ctrl.sv
// Pops PS/2 codes, decodes maze moves and queues them for the maze logic.
// Optional pause key is enabled by defining KB_MOVE_PAUSE_EN.
module kb_move_ctrl
  import kb_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       key_code,
  input  logic             kb_buf_empty,
  output logic             rd_key_code,
  output logic             cmd_valid,
  output logic [2:0]       cmd,
  input  logic             cmd_ready,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             busy
`ifdef KB_MOVE_PAUSE_EN
  ,
  output logic             paused
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  state_t     state_nxt;
  logic [7:0] code_q;
  key_dec_t   dec;
  logic       push;
  logic       drop;
  logic       q_ready;
  cmd_t       q_data;

  assign dec = key_decode(code_q);

`ifdef KB_MOVE_PAUSE_EN
  logic pause_tgl;
  logic pause_clr;
`endif

  always_comb begin
    state_nxt   = state;
    rd_key_code = 1'b0;
    push        = 1'b0;
    drop        = 1'b0;
`ifdef KB_MOVE_PAUSE_EN
    pause_tgl   = 1'b0;
    pause_clr   = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (!kb_buf_empty) begin
          state_nxt = S_POP;
        end
      end
      S_POP: begin
        rd_key_code = 1'b1;
        state_nxt   = S_DECODE;
      end
      S_DECODE: begin
        state_nxt = S_IDLE;
`ifdef KB_MOVE_PAUSE_EN
        pause_clr = dec.hit && dec.cmd == CMD_RESTART;
        if (code_q == KEY_P) begin
          pause_tgl = 1'b1;
        end else if (!dec.hit
                  || (paused && dec.cmd != CMD_RESTART)) begin
          drop = 1'b1;
        end else if (q_ready) begin
          push = 1'b1;
        end else begin
          drop = 1'b1;
        end
`else
        if (dec.hit && q_ready) begin
          push = 1'b1;
        end else begin
          drop = 1'b1;
        end
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      code_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && !kb_buf_empty) begin
        code_q <= key_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + CNT_ONE;
    end
  end

`ifdef KB_MOVE_PAUSE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      paused <= 1'b0;
    end else if (pause_tgl) begin
      paused <= !paused;
    end else if (pause_clr) begin
      paused <= 1'b0;
    end
  end
`endif

  kb_cmd_fifo #(
    .DEPTH(CMD_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .in_valid (push),
    .in_data  (dec.cmd),
    .in_ready (q_ready),
    .out_valid(cmd_valid),
    .out_ready(cmd_ready),
    .out_data (q_data)
  );

  assign cmd  = q_data;
  assign busy = (state != S_IDLE) || cmd_valid;

endmodule
